// File: rtl/sad_controller.sv
// sad_controller: sequences the sum-of-absolute-differences engine.
// Walks two synchronous-read pixel memories over N addresses, forms
// |A-B| per pair via subtract and two's-complement negate, accumulates,
// and presents the 16-bit SAD with a one-cycle done pulse.
module sad_controller #(
    parameter int N      = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        a_data,
    input  logic [7:0]        b_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sad
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] acc;
    logic        data_valid;
    logic [15:0] diff;
    logic [15:0] mag;
    logic [15:0] acc_sum;

    // Abs-diff of the returned pixel pair and the running sum including it
    always_comb begin
        diff    = {8'b0, a_data} - {8'b0, b_data};
        mag     = diff[15] ? (~diff + 16'd1) : diff;
        acc_sum = acc + mag;
    end

    // Control FSM, address generation and accumulation; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            rd_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sad        <= '0;
            acc        <= '0;
            data_valid <= 1'b0;
        end else begin
            // Memory returns data one cycle after a read was issued
            data_valid <= rd_en;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        addr  <= '0;
                        rd_en <= 1'b1;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (data_valid) begin
                        acc <= acc_sum;
                    end
                    if (addr == LAST_ADDR) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // sad is loaded with the final sum here so it is already
                    // valid in the DONE cycle alongside the done pulse
                    acc   <= acc_sum;
                    sad   <= acc_sum;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sad_controller.md
# sad_controller

Sequencer for the sum-of-absolute-differences engine. On a start pulse it walks two synchronous-read pixel memories (block A, block B) over N addresses. For each pair it forms the 16-bit difference, converts negative results to magnitude with a two's-complement negate, and accumulates. It then presents the 16-bit SAD with a one-cycle done pulse. It sits between the top-level search control and the pixel buffers, and owns the shared subtract/negate/accumulate datapath.

## Interface
- N, default 16: pixel pairs per SAD; legal range 1..256.
- ADDR_W, default 8: address width; must satisfy 2^ADDR_W ≥ N.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a SAD computation; sampled only in IDLE.
- rd_en  output  1  read enable to both pixel memories.
- addr  output  ADDR_W  shared read address to both memories.
- a_data  input  8  pixel from memory A, valid one cycle after addr/rd_en.
- b_data  input  8  pixel from memory B, valid one cycle after addr/rd_en.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; sad is valid in that cycle.
- sad  output  16  last completed SAD; holds until the next completion.

## Operation
- Reset values: state=IDLE, addr=0, rd_en=0, busy=0, done=0, sad=0, accumulator=0, counter=0.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered.
- IDLE: if start=1, clear the accumulator, set addr=0, rd_en=1, and go to RUN. Otherwise hold.
- RUN: addr increments by 1 each cycle while rd_en=1.
  - The accumulator adds the abs-diff of the data returned for the previous address. No add happens in the first RUN cycle.
  - After addr=N-1 has been presented, drop rd_en and go to DRAIN.
- DRAIN: accumulate the pair for address N-1, then go to DONE.
- DONE: sad ← accumulator, done=1 for exactly one cycle, then return to IDLE.
- Abs-diff path:
  - d = {8'b0,a_data} − {8'b0,b_data}, 16-bit.
  - If d[15]=1, magnitude = ~d + 1; otherwise magnitude = d.
  - Magnitude range is 0..255.
- Accumulator: 16-bit unsigned. Max 256×255 = 65280, so no overflow is possible within the legal N range, and no saturation logic exists.
- start while busy (RUN, DRAIN, DONE) is ignored. It is not queued.
- start asserted in the cycle after done (back in IDLE) launches a new run. This is the fastest restart.
- rst at any time aborts the run and forces the reset values, including sad=0, on the next edge.
- N=1: RUN lasts one cycle (addr=0), then DRAIN, then DONE.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycles 1..N: RUN; addr=k is visible in cycle k+1 with rd_en=1.
- The data for addr k arrives in cycle k+2 and is added at the end of that cycle.
- Cycle N+1: DRAIN; rd_en=0; the last pair is added.
- Cycle N+2: DONE; done=1 and sad valid. busy=1 in cycles 1..N+2.
- Latency from start sample to done: N+2 cycles. Minimum start-to-start period: N+3 cycles.
- The memory contract is a registered read with 1-cycle latency. Data are ignored when no read was issued in the prior cycle.

## Test plan
- Reset, then N=16, all A=10, all B=3, start pulse → addr 0..15 in cycles 1..16; done=1 in cycle 18 only; sad=112; busy=0 in cycle 19.
- All A=0, all B=255 (exercises the negate path) → sad=4080. Then swap A and B → sad=4080 again.
- Mixed data: A[k]=k, B[k]=15−k for k=0..15 → sad=128. Also check that sad holds 128 across 20 idle cycles.
- start held high for the entire run → only one done pulse per N+3-cycle period. The second run launches the cycle after done, with the accumulator cleared (sad equals the single-run value, not double).
- rst asserted in cycle 8 of a run → next cycle: state IDLE, rd_en=0, busy=0, sad=0. No done pulse follows. A fresh start then gives the correct full result.
- N=1 build with A=0x05, B=0x09 → addr=0 in cycle 1, done in cycle 3, sad=4.
